ls148_code_decoder: RTL and testbench



---
 rtl/ls148_pkg.sv | 35 +++
 rtl/ls148_stab_filter.sv | 51 +++++
 rtl/ls148_code_decoder.sv | 109 ++++++++++
 tb/tb_ls148_code_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ls148_pkg.sv
// Shared definitions for the 74LS148 receive path.
// Provides line-count/code-width constants, the idle line image, an
// active-low one-hot decoder and a lowest-set-bit finder for the pending vector.
package ls148_pkg;

  localparam int LS148_LINES  = 8;
  localparam int LS148_CODE_W = 3;

  localparam logic [LS148_LINES-1:0] LS148_IDLE_LINES = 8'hFF;

  typedef struct packed {
    logic                    found;
    logic [LS148_CODE_W-1:0] idx;
  } lowest_t;

  // Active-low one-hot image of a 3-bit code.
  function automatic logic [LS148_LINES-1:0] onehot_n(input logic [LS148_CODE_W-1:0] code);
    return ~(8'b1 << code);
  endfunction

  // Lowest-index set bit; scanning downward lets the lowest index win.
  function automatic lowest_t lowest_set(input logic [LS148_LINES-1:0] vec);
    lowest_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = LS148_LINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = LS148_CODE_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ls148_stab_filter.sv
// Stability filter for the encoder sample.
// Registers din every clock, counts consecutive identical samples (saturating
// at STABLE_CYCLES), and flags the first qualified cycle of each stable episode.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   din         raw input word
//   sample      registered copy of din
//   qual        sample has been identical for STABLE_CYCLES samples
//   fresh       first cycle of qual within the current stable episode
module ls148_stab_filter #(
  parameter int               STABLE_CYCLES = 2,
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] RST_VAL       = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sample,
  output logic             qual,
  output logic             fresh
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic [3:0] cnt;
  logic       qual_d;
  logic       same;

  assign same  = (din == sample);
  assign qual  = (cnt == CNT_MAX);
  // qual_d is only high when the previous cycle was qualified on this same
  // sample, so any change (or loss of qualification) re-arms the event.
  assign fresh = qual & ~qual_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample <= RST_VAL;
      cnt    <= 4'd0;
      qual_d <= 1'b0;
    end else begin
      sample <= din;
      if (same) begin
        cnt <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 4'd1;
      end else begin
        cnt <= 4'd1;
      end
      qual_d <= qual & same;
    end
  end

endmodule

// File: rtl/ls148_code_decoder.sv
// Receive side of an 8-line priority-encoder interface.
// Debounces {gs_n,a}, latches each newly stable request into a pending vector
// and hands indices out one at a time over valid/ready, lowest index first.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   a, gs_n, eo  encoder code, group-select (low = active), enable-out
//   line_n       registered active-low one-hot of the stable code (FF = idle)
//   out_valid    an index is presented in the output slot
//   out_idx      presented index
//   out_ready    consumer accepts out_idx
//   idle_o       qualified, registered ~eo
//   ovf          sticky: request arrived for an index already pending or in slot
module ls148_code_decoder
  import ls148_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LS148_CODE_W-1:0] a,
  input  logic                    gs_n,
  input  logic                    eo,
  output logic [LS148_LINES-1:0]  line_n,
  output logic                    out_valid,
  output logic [LS148_CODE_W-1:0] out_idx,
  input  logic                    out_ready,
  output logic                    idle_o,
  output logic                    ovf
);

  logic [LS148_CODE_W:0]   samp;
  logic                    s_gs_n;
  logic [LS148_CODE_W-1:0] s_a;
  logic                    qual;
  logic                    fresh;
  logic                    evt;
  logic                    eo_s;
  logic [LS148_LINES-1:0]  pending;
  logic [LS148_LINES-1:0]  pending_nxt;
  lowest_t                 low;
  logic                    load;
  logic                    ovf_hit;

  ls148_stab_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .WIDTH         (LS148_CODE_W + 1),
    .RST_VAL       ('1)
  ) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({gs_n, a}),
    .sample (samp),
    .qual   (qual),
    .fresh  (fresh)
  );

  assign s_gs_n = samp[LS148_CODE_W];
  assign s_a    = samp[LS148_CODE_W-1:0];
  assign evt    = fresh & ~s_gs_n;

  assign low  = lowest_set(pending);
  assign load = ~out_valid | out_ready;

  // A slot occupant that is being accepted this cycle is not a collision.
  assign ovf_hit = evt & (pending[s_a] | (out_valid & (out_idx == s_a) & ~out_ready));

  // Clear for the slot load first, then the event set, so a same-bit
  // arrival survives the clear.
  always_comb begin
    pending_nxt = pending;
    if (load && low.found) begin
      pending_nxt[low.idx] = 1'b0;
    end
    if (evt) begin
      pending_nxt[s_a] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eo_s      <= 1'b1;
      pending   <= '0;
      line_n    <= LS148_IDLE_LINES;
      idle_o    <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      eo_s    <= eo;
      pending <= pending_nxt;
      if (qual) begin
        line_n <= s_gs_n ? LS148_IDLE_LINES : onehot_n(s_a);
        idle_o <= ~eo_s;
      end
      if (ovf_hit) begin
        ovf <= 1'b1;
      end
      if (load) begin
        if (low.found) begin
          out_valid <= 1'b1;
          out_idx   <= low.idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ls148_code_decoder.sv
module tb_ls148_code_decoder;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a;
  logic       gs_n;
  logic       eo;
  logic [7:0] line_n;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_ready;
  logic       idle_o;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ls148_code_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .gs_n      (gs_n),
    .eo        (eo),
    .line_n    (line_n),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .idle_o    (idle_o),
    .ovf       (ovf)
  );

  // Reference model: run length of identical samples (uncapped), a pending
  // set, and an output slot; expected transfers go into exp_q.
  int         run;
  logic [3:0] last;
  logic       last_eo;
  logic [7:0] m_pend;
  logic [7:0] m_line;
  logic       m_valid;
  logic [2:0] m_idx;
  logic       m_idle;
  logic       m_ovf;
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic gs, input logic [2:0] av, input logic eov,
                            input logic rdy, input logic rst);
    logic [7:0] old_pend;
    logic       ev;
    logic       found;
    int         code;
    if (!rst) begin
      run = 0; last = 4'hF; last_eo = 1'b1;
      m_pend = 8'h00; m_line = 8'hFF; m_valid = 1'b0; m_idx = 3'd0;
      m_idle = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
      return;
    end
    old_pend = m_pend;
    code = int'(last[2:0]);
    // A request fires exactly when its run reaches the stability threshold.
    ev = (run == SC) && !last[3];
    if (run >= SC) begin
      for (int i = 0; i < 8; i++) m_line[i] = last[3] ? 1'b1 : (i != code);
      m_idle = !last_eo;
    end
    if (ev && (old_pend[code] || (m_valid && int'(m_idx) == code && !rdy))) m_ovf = 1'b1;
    if (!m_valid || rdy) begin
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (old_pend[i] && !found) begin
          found = 1'b1;
          m_idx = 3'(i);
          m_pend[i] = 1'b0;
          exp_q.push_back(3'(i));
        end
      end
      m_valid = found;
    end
    if (ev) m_pend[code] = 1'b1;
    if (run > 0 && {gs, av} == last) run++;
    else run = 1;
    last = {gs, av};
    last_eo = eov;
  endtask

  task automatic cycle(input logic gs, input logic [2:0] av, input logic eov,
                       input logic rdy, input logic rst);
    gs_n = gs; a = av; eo = eov; out_ready = rdy; rst_n = rst;
    model_step(gs, av, eov, rdy, rst);
    @(posedge clk);
    #1;
    chk("line_n", 32'(line_n), 32'(m_line));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk("out_idx", 32'(out_idx), 32'(m_idx));
    chk("idle_o", 32'(idle_o), 32'(m_idle));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic hold(input logic gs, input logic [2:0] av, input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(gs, av, gs ? 1'b0 : 1'b1, rdy, 1'b1);
  endtask

  // Scoreboard monitor: every accepted transfer must match the next expected index.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got idx %0d expected no transfer at %0t", out_idx, $time);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_idx", 32'(out_idx), 32'(e));
        end
      end
    end
  end

  initial begin
    logic       rg;
    logic [2:0] ra;
    int         len;

    // Reset and idle
    cycle(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
    chk("rst_line_n", 32'(line_n), 32'hFF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_idle_o", 32'(idle_o), 32'h0);
    hold(1'b1, 3'd7, 1'b1, 10);

    // Single request for line 5
    hold(1'b0, 3'd5, 1'b1, 2);
    chk("line5_not_yet", 32'(line_n), 32'hFF);
    hold(1'b0, 3'd5, 1'b1, 1);
    chk("line5_edge3", 32'(line_n), 32'hDF);
    chk("idx5_not_yet", 32'(out_valid), 32'h0);
    hold(1'b0, 3'd5, 1'b1, 1);
    chk("idx5_valid", 32'(out_valid), 32'h1);
    chk("idx5_val", 32'(out_idx), 32'h5);
    hold(1'b0, 3'd5, 1'b1, 4);
    hold(1'b1, 3'd7, 1'b1, 4);

    // One-cycle glitch must not produce an event
    hold(1'b0, 3'd2, 1'b1, 1);
    hold(1'b1, 3'd7, 1'b1, 5);
    chk("glitch_line_n", 32'(line_n), 32'hFF);

    // Stalled consumer, 6 then 1
    hold(1'b0, 3'd6, 1'b0, 4);
    hold(1'b0, 3'd1, 1'b0, 4);
    hold(1'b1, 3'd7, 1'b0, 3);
    chk("stall_idx6", 32'(out_idx), 32'h6);
    hold(1'b1, 3'd7, 1'b1, 5);

    // Re-request of the index held in the slot
    hold(1'b0, 3'd3, 1'b0, 4);
    hold(1'b1, 3'd7, 1'b0, 3);
    hold(1'b0, 3'd3, 1'b0, 4);
    hold(1'b1, 3'd7, 1'b0, 3);
    chk("ovf_set", 32'(ovf), 32'h1);
    hold(1'b1, 3'd7, 1'b1, 5);

    // Reset with slot full and pending = 8'h24
    hold(1'b0, 3'd1, 1'b0, 3);
    hold(1'b0, 3'd2, 1'b0, 3);
    hold(1'b0, 3'd5, 1'b0, 3);
    hold(1'b1, 3'd7, 1'b0, 2);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_line_n", 32'(line_n), 32'hFF);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    hold(1'b1, 3'd7, 1'b1, 6);

    // Randomized episodes
    for (int seg = 0; seg < 800; seg++) begin
      rg  = ($urandom_range(0, 3) == 0);
      ra  = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        cycle(rg, ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 199) != 0));
      end
    end

    hold(1'b1, 3'd7, 1'b1, 12);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding transfers expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
